// File: rtl/fpu_ret_pkg.sv
// fpu_ret_pkg: shared types and field positions for FP return words
// and collector FIFO entries.
package fpu_ret_pkg;

    localparam int NPORT = 6;
    localparam int RETW  = 14;

    localparam int FLG_NV   = 4;
    localparam int FLG_DZ   = 3;
    localparam int FLG_OF   = 2;
    localparam int FLG_UF   = 1;
    localparam int FLG_NX   = 0;
    localparam int TRAP_BIT = 5;

    typedef logic [RETW-1:0] fpu_ret_t;

    typedef struct packed {
        logic [2:0] port;
        fpu_ret_t   ret;
    } fifo_ent_t;

    function automatic logic [4:0] ret_flags(input fpu_ret_t r);
        return r[FLG_NV:FLG_NX];
    endfunction

endpackage

// File: rtl/fpu_ret_compact.sv
// fpu_ret_compact: prefix popcount of the per-port valids, giving each
// valid port its write slot relative to the write pointer.
import fpu_ret_pkg::*;

module fpu_ret_compact (
    input  logic [NPORT-1:0]      en,
    output logic [NPORT-1:0][2:0] slot,
    output logic [2:0]            total
);

    logic [2:0] acc;

    always_comb begin
        acc  = '0;
        slot = '0;
        for (int k = 0; k < NPORT; k++) begin
            slot[k] = acc;
            acc     = acc + {2'b00, en[k]};
        end
        total = acc;
    end

endmodule

// File: rtl/fpu_ret_collector.sv
// fpu_ret_collector: compacts FP completion returns into an in-order FIFO
// with sticky IEEE flags. Optional macro FPRC_TRAP_EN adds trap_pend.
import fpu_ret_pkg::*;

module fpu_ret_collector #(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPORT*RETW-1:0]   in_ret,
    input  logic [NPORT-1:0]        in_ret_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RETW-1:0]         out_ret,
    output logic [2:0]              out_port,
    output logic                    stall,
    output logic [$clog2(DEPTH):0]  count,
    output logic [4:0]              flags_sticky,
    input  logic                    flags_clr
`ifdef FPRC_TRAP_EN
    ,
    output logic                    trap_pend
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]            wr_ptr;
    logic [CW-1:0]            rd_ptr;
    fifo_ent_t                mem [DEPTH];
    fifo_ent_t                head;
    logic [NPORT-1:0]         wr_en;
    logic [NPORT-1:0][2:0]    slot;
    logic [2:0]               push_n;
    logic                     nonempty;
    logic                     pop;
    logic [CW:0]              count_next;
    logic [4:0]               flags_next;

    // A push attempted while stalled is dropped for the whole cycle.
    assign wr_en = stall ? '0 : in_ret_en;

    fpu_ret_compact u_compact (
        .en    (wr_en),
        .slot  (slot),
        .total (push_n)
    );

    assign count    = wr_ptr - rd_ptr;
    assign nonempty = (count != '0);
    assign head     = mem[rd_ptr[AW-1:0]];

`ifdef FPRC_TRAP_EN
    assign out_valid = nonempty & ~trap_pend;
`else
    assign out_valid = nonempty;
`endif

    assign out_ret  = nonempty ? head.ret  : '0;
    assign out_port = nonempty ? head.port : '0;
    assign pop      = out_valid & out_ready;

    assign count_next = {1'b0, count}
                      + {{(CW-2){1'b0}}, push_n}
                      - {{CW{1'b0}}, pop};

    assign flags_next = (flags_clr ? 5'd0 : flags_sticky)
                      | (pop ? ret_flags(head.ret) : 5'd0);

    always_ff @(posedge clk) begin
        for (int k = 0; k < NPORT; k++) begin
            if (wr_en[k]) begin
                mem[wr_ptr[AW-1:0] + AW'(slot[k])] <= '{
                    port: 3'(k),
                    ret:  in_ret[k*RETW +: RETW]
                };
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            stall        <= 1'b0;
            flags_sticky <= '0;
        end else begin
            wr_ptr       <= wr_ptr + CW'(push_n);
            rd_ptr       <= rd_ptr + CW'(pop);
            stall        <= count_next > (CW+1)'(DEPTH - NPORT);
            flags_sticky <= flags_next;
        end
    end

`ifdef FPRC_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trap_pend <= 1'b0;
        end else begin
            trap_pend <= (pop & head.ret[TRAP_BIT])
                       | (trap_pend & ~flags_clr);
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst && stall) begin
            assert (in_ret_en == '0)
                else $error("fpu_ret_collector: push while stalled, dropped");
        end
    end
`endif

endmodule

// File: tb/tb_fpu_ret_collector.sv
// tb_fpu_ret_collector: directed and random stimulus against a queue
// model of the return collector.
import fpu_ret_pkg::*;

module tb_fpu_ret_collector;

    localparam int DEPTH = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NPORT*RETW-1:0] in_ret = '0;
    logic [NPORT-1:0]      in_ret_en = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [RETW-1:0]       out_ret;
    logic [2:0]            out_port;
    logic                  stall;
    logic [4:0]            count;
    logic [4:0]            flags_sticky;
    logic                  flags_clr = 1'b0;
`ifdef FPRC_TRAP_EN
    logic                  trap_pend;
`endif

    always #5 clk = ~clk;

    fpu_ret_collector #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_ret       (in_ret),
        .in_ret_en    (in_ret_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ret      (out_ret),
        .out_port     (out_port),
        .stall        (stall),
        .count        (count),
        .flags_sticky (flags_sticky),
        .flags_clr    (flags_clr)
`ifdef FPRC_TRAP_EN
        ,
        .trap_pend    (trap_pend)
`endif
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [16:0] q[$];
    logic [4:0]  m_flags = '0;
    logic        m_stall = 1'b0;
    logic        m_trap = 1'b0;
    int          max_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out();
        logic v;
        v = (q.size() != 0) && !m_trap;
        chk("out_valid", 32'(out_valid), 32'(v));
        if (v) begin
            chk("out_port", 32'(out_port), 32'(q[0][16:14]));
            chk("out_ret", 32'(out_ret), 32'(q[0][13:0]));
        end
        chk("count", 32'(count), 32'(q.size()));
        chk("stall", 32'(stall), 32'(m_stall));
        chk("flags", 32'(flags_sticky), 32'(m_flags));
`ifdef FPRC_TRAP_EN
        chk("trap_pend", 32'(trap_pend), 32'(m_trap));
`endif
    endtask

    // One cycle: check state, drive inputs, advance the model.
    task automatic step(input logic [NPORT-1:0] en,
                        input logic [NPORT*RETW-1:0] rets,
                        input logic rdy, input logic clr);
        logic        pop;
        logic [16:0] h;
        @(negedge clk);
        check_out();
        if (m_stall) en = '0;
        in_ret_en = en;
        in_ret    = rets;
        out_ready = rdy;
        flags_clr = clr;
        pop = (q.size() != 0) && !m_trap && rdy;
        h   = pop ? q[0] : 17'd0;
        m_flags = (clr ? 5'd0 : m_flags) | (pop ? h[4:0] : 5'd0);
`ifdef FPRC_TRAP_EN
        m_trap = (pop && h[5]) || (m_trap && !clr);
`endif
        if (pop) void'(q.pop_front());
        for (int k = 0; k < NPORT; k++)
            if (en[k]) q.push_back({3'(k), rets[k*RETW +: RETW]});
        m_stall = (DEPTH - q.size()) < NPORT;
        if (q.size() > max_cnt) max_cnt = q.size();
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NPORT*RETW-1:0] one(input int k,
                                                  input logic [13:0] r);
        logic [NPORT*RETW-1:0] v;
        v = '0;
        v[k*RETW +: RETW] = r;
        return v;
    endfunction

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++)
            step('0, '0, 1'b1, 1'b0);
        step('0, '0, 1'b0, 1'b1);
    endtask

    logic [NPORT*RETW-1:0] rets;
    logic [95:0]           rnd;

    initial begin
        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_flags", 32'(flags_sticky), 0);
        chk("rst_ret", 32'(out_ret), 0);
        chk("rst_port", 32'(out_port), 0);
        @(negedge clk);
        rst = 1'b1;

        // single push on port 2
        step(6'b000100, one(2, 14'h0011), 1'b1, 1'b0);
        after_edge();
        chk("single_valid", 32'(out_valid), 1);
        chk("single_port", 32'(out_port), 2);
        chk("single_ret", 32'(out_ret), 32'h11);
        step('0, '0, 1'b1, 1'b0);
        after_edge();
        chk("single_flags", 32'(flags_sticky), 32'b10001);
        chk("single_count", 32'(count), 0);
        step('0, '0, 1'b0, 1'b1);

        // six-wide burst, drained in port order
        rets = '0;
        for (int k = 0; k < NPORT; k++) rets[k*RETW +: RETW] = 14'(k);
        step(6'h3F, rets, 1'b0, 1'b0);
        after_edge();
        chk("burst_count", 32'(count), 6);
        for (int i = 0; i < NPORT; i++) begin
            chk("burst_port", 32'(out_port), 32'(i));
            chk("burst_ret", 32'(out_ret), 32'(i));
            step('0, '0, 1'b1, 1'b0);
            after_edge();
        end
        chk("burst_empty", 32'(count), 0);
        step('0, '0, 1'b0, 1'b1);

        // backpressure threshold
        step(6'h07, rets, 1'b0, 1'b0);
        step(6'h38, rets, 1'b0, 1'b0);
        step(6'h07, rets, 1'b0, 1'b0);
        step(6'h01, rets, 1'b0, 1'b0);
        after_edge();
        chk("bp_count10", 32'(count), 10);
        chk("bp_nostall", 32'(stall), 0);
        step(6'h02, rets, 1'b0, 1'b0);
        after_edge();
        chk("bp_count11", 32'(count), 11);
        chk("bp_stall", 32'(stall), 1);
        drain();

        // flags clear racing a pop
        step(6'h01, one(0, 14'h0004), 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        step(6'h01, one(0, 14'h0001), 1'b0, 1'b0);
        after_edge();
        chk("race_pre", 32'(flags_sticky), 32'b00100);
        step('0, '0, 1'b1, 1'b1);
        after_edge();
        chk("race_post", 32'(flags_sticky), 32'b00001);
        drain();

        // pointer wrap with continuous pops
        max_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0)
                step(((c / 3) % 2) ? 6'h38 : 6'h07,
                     {6{14'(c)}}, 1'b1, 1'b0);
            else
                step('0, '0, 1'b1, 1'b0);
        end
        chk("wrap_max", 32'(max_cnt <= 3), 1);
        drain();

`ifdef FPRC_TRAP_EN
        rets = '0;
        rets[0 +: RETW] = 14'h0020;
        for (int k = 1; k < 4; k++) rets[k*RETW +: RETW] = 14'h0040;
        step(6'h0F, rets, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        after_edge();
        chk("trap_set", 32'(trap_pend), 1);
        chk("trap_novalid", 32'(out_valid), 0);
        chk("trap_count", 32'(count), 3);
        step('0, '0, 1'b1, 1'b1);
        after_edge();
        chk("trap_clr", 32'(out_valid), 1);
        drain();
`endif

        // mid-operation reset
        step(6'h1F, rets, 1'b0, 1'b0);
        after_edge();
        in_ret_en = '0;
        rst = 1'b0;
        #1;
        chk("mrst_count", 32'(count), 0);
        chk("mrst_valid", 32'(out_valid), 0);
        chk("mrst_stall", 32'(stall), 0);
        q.delete();
        m_flags = '0;
        m_stall = 1'b0;
        m_trap  = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            rnd  = {$urandom(), $urandom(), $urandom()};
            rets = rnd[NPORT*RETW-1:0];
            step(NPORT'($urandom() & $urandom()),
                 rets, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0));
        end
        @(negedge clk);
        check_out();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
